// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end for a word-addressed data memory. A byte-address
// request from the core is checked for alignment, reserved size and range.
// The unit then drives the memory word address, the byte-lane selects, the
// lane-replicated store data and a read or write strobe. For loads, it
// extracts the addressed lanes and sign- or zero-extends them to 32 bits.
// Only one access is in flight at a time.
//
// Ports
//   clk           rising-edge clock
//   clr_n         asynchronous active-low reset
//   req           access request, sampled only while ready=1
//   we            1 = store, 0 = load
//   op            [1:0] size (00 byte, 01 half, 10 word, 11 reserved); [2] unsigned load
//   addr          byte address
//   wdata         right-justified store data
//   ready         unit idle; a request is accepted in this cycle
//   done          one-cycle completion pulse
//   addr_err      error flag, valid with done
//   rdata         load result, valid with done, held until the next load completes
//   mem_addr      memory word address (addr[MEM_ADDR_BITS+1:2])
//   mem_sel       byte-lane enables, lane 0 = byte offset 0
//   mem_data_in   store data replicated across lanes
//   mem_str       memory write strobe
//   mem_ld        memory read strobe
//   mem_data_out  lane-masked memory read data, valid the cycle after the mem_ld edge
module mem_access_unit #(
   parameter int MEM_ADDR_BITS = 10,
   parameter bit RANGE_CHECK   = 1'b1
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     req,
   input  logic                     we,
   input  logic [2:0]               op,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic                     ready,
   output logic                     done,
   output logic                     addr_err,
   output logic [31:0]              rdata,
   output logic [MEM_ADDR_BITS-1:0] mem_addr,
   output logic [3:0]               mem_sel,
   output logic [31:0]              mem_data_in,
   output logic                     mem_str,
   output logic                     mem_ld,
   input  logic [31:0]              mem_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                   state_q, state_d;
   logic                     we_q;
   logic [2:0]               op_q;
   logic [1:0]               off_q;
   logic                     err_q;
   logic [31:0]              rdata_q;
   logic [MEM_ADDR_BITS-1:0] memAddr_q;
   logic [3:0]               memSel_q;
   logic [31:0]              memData_q;

   logic                     accept;
   logic                     reqErr;
   logic                     rangeErr;
   logic [3:0]               reqSel;
   logic [31:0]              reqData;
   logic [31:0]              shifted;
   logic [31:0]              loadVal;
   logic                     loadResp;

   assign accept   = (state_q == IDLE) && req;
   assign loadResp = (state_q == RESP) && !we_q && !err_q;

   // Decode the incoming request. A shift is used for the range test so the
   // logic stays valid for any memory depth.
   always_comb begin
      rangeErr = 1'b0;
      if (RANGE_CHECK) begin
         rangeErr = (addr >> (MEM_ADDR_BITS + 2)) != 32'd0;
      end
      reqErr  = rangeErr;
      reqSel  = 4'b0000;
      reqData = wdata;
      unique case (op[1:0])
         2'b00: begin
            reqSel  = 4'b0001 << addr[1:0];
            reqData = {4{wdata[7:0]}};
         end
         2'b01: begin
            reqSel  = addr[1] ? 4'b1100 : 4'b0011;
            reqData = {2{wdata[15:0]}};
            if (addr[0]) reqErr = 1'b1;
         end
         2'b10: begin
            reqSel = 4'b1111;
            if (addr[1:0] != 2'b00) reqErr = 1'b1;
         end
         default: reqErr = 1'b1;
      endcase
   end

   // Sequence one access. Errors skip ACCESS, so the memory never sees a strobe for them.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req) state_d = reqErr ? RESP : ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Align the returned lanes to bit 0, then extend them to 32 bits.
   // op[2] selects zero-extension. A word load ignores op[2].
   always_comb begin
      shifted = mem_data_out >> {off_q, 3'b000};
      unique case (op_q[1:0])
         2'b00:   loadVal = {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
         2'b01:   loadVal = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
         default: loadVal = shifted;
      endcase
   end

   // Hold the state and the request. The memory-facing registers load only on
   // an accepted request without an error, so a rejected access leaves them unchanged.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         op_q      <= 3'b000;
         off_q     <= 2'b00;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
         memAddr_q <= '0;
         memSel_q  <= 4'b0000;
         memData_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q  <= we;
            op_q  <= op;
            off_q <= addr[1:0];
            err_q <= reqErr;
            if (!reqErr) begin
               memAddr_q <= addr[MEM_ADDR_BITS+1:2];
               memSel_q  <= reqSel;
               memData_q <= reqData;
            end
         end
         if (loadResp) rdata_q <= loadVal;
      end
   end

   assign ready       = (state_q == IDLE);
   assign done        = (state_q == RESP);
   assign addr_err    = done && err_q;
   assign rdata       = loadResp ? loadVal : rdata_q;
   assign mem_addr    = memAddr_q;
   assign mem_sel     = memSel_q;
   assign mem_data_in = memData_q;
   assign mem_str     = (state_q == ACCESS) && we_q;
   assign mem_ld      = (state_q == ACCESS) && !we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It contains a word memory model for each DUT
// instance and a byte-array reference model of the load/store rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic        ready, done, addr_err, mem_str, mem_ld;
   logic [31:0] rdata, mem_data_in, memOut = 32'd0;
   logic [9:0]  mem_addr;
   logic [3:0]  mem_sel;

   // Second instance with the range check disabled
   logic        req1 = 1'b0;
   logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
   logic        ready1, done1, addrErr1, memStr1, memLd1;
   logic [31:0] rdata1, memDataIn1, memOut1 = 32'd0;
   logic [9:0]  memAddr1;
   logic [3:0]  memSel1;

   logic [31:0] memWords  [1024] = '{default: 32'd0};
   logic [31:0] memWords1 [1024] = '{default: 32'd0};
   logic [7:0]  refMem    [4096] = '{default: 8'd0};
   logic [31:0] refRdata = 32'd0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_ADDR_BITS(10), .RANGE_CHECK(1'b1)) dut (
      .clk(clk), .clr_n(clr_n), .req(req), .we(we), .op(op), .addr(addr), .wdata(wdata),
      .ready(ready), .done(done), .addr_err(addr_err), .rdata(rdata),
      .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_data_in(mem_data_in),
      .mem_str(mem_str), .mem_ld(mem_ld), .mem_data_out(memOut));

   mem_access_unit #(.MEM_ADDR_BITS(10), .RANGE_CHECK(1'b0)) dut1 (
      .clk(clk), .clr_n(clr_n), .req(req1), .we(1'b1), .op(3'b010), .addr(addr1), .wdata(wdata1),
      .ready(ready1), .done(done1), .addr_err(addrErr1), .rdata(rdata1),
      .mem_addr(memAddr1), .mem_sel(memSel1), .mem_data_in(memDataIn1),
      .mem_str(memStr1), .mem_ld(memLd1), .mem_data_out(memOut1));

   // Word memory model: lane-masked writes, registered lane-masked reads, output cleared when ld=0
   always @(posedge clk) begin
      logic [31:0] mask, tmp;
      mask = {{8{mem_sel[3]}}, {8{mem_sel[2]}}, {8{mem_sel[1]}}, {8{mem_sel[0]}}};
      tmp  = memWords[mem_addr];
      if (mem_str) memWords[mem_addr] <= (tmp & ~mask) | (mem_data_in & mask);
      memOut <= mem_ld ? (tmp & mask) : 32'd0;
   end

   always @(posedge clk) begin
      logic [31:0] mask, tmp;
      mask = {{8{memSel1[3]}}, {8{memSel1[2]}}, {8{memSel1[1]}}, {8{memSel1[0]}}};
      tmp  = memWords1[memAddr1];
      if (memStr1) memWords1[memAddr1] <= (tmp & ~mask) | (memDataIn1 & mask);
      memOut1 <= memLd1 ? (tmp & mask) : 32'd0;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Byte-level reference model. It returns the expected error, lane selects,
   // replicated store data and result, and it updates the model memory.
   function automatic void refAccess(input logic w, input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] d, output logic e, output logic [3:0] s,
                                     output logic [31:0] di, output logic [31:0] r);
      int n;
      int base;
      logic [31:0] v;
      n    = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
      e    = (o[1:0] == 2'b11) || ((a % n) != 0) || (a >= 32'd4096);
      base = int'(a[11:0]);
      s    = 4'b0000;
      di   = 32'd0;
      for (int k = 0; k < 4; k++) di[8*k +: 8] = d[8*(k % n) +: 8];
      for (int i = 0; i < n; i++) s[(base % 4) + i] = 1'b1;
      if (!e && w) begin
         for (int i = 0; i < n; i++) refMem[base + i] = d[8*i +: 8];
      end else if (!e) begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[base + i];
         if (n < 4 && !o[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         refRdata = v;
      end
      r = refRdata;
   endfunction

   // Drive one request and collect what the DUT does until done or timeout
   task automatic applyStimulus(input logic w, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] d, output int lat, output logic err,
                                output logic [31:0] rd, output logic sawStr, output logic sawLd,
                                output logic [3:0] sel, output logic [31:0] din,
                                output logic [9:0] maddr);
      @(negedge clk);
      checkOutput("readyBeforeReq", {31'd0, ready}, 32'd1);
      req = 1'b1; we = w; op = o; addr = a; wdata = d;
      lat = 99; err = 1'b0; rd = 32'd0; sawStr = 1'b0; sawLd = 1'b0;
      sel = 4'b0000; din = 32'd0; maddr = 10'd0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (mem_str && mem_ld) checkOutput("strobesExclusive", 32'd1, 32'd0);
         if (mem_str || mem_ld) begin
            sawStr = sawStr | mem_str;
            sawLd  = sawLd | mem_ld;
            sel = mem_sel; din = mem_data_in; maddr = mem_addr;
         end
         if (done) begin
            lat = c; err = addr_err; rd = rdata;
            break;
         end
      end
   endtask

   typedef struct {
      logic        w;
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] d;
      logic        eErr;
      logic [3:0]  eSel;
      logic [31:0] eDin;
      logic [31:0] eRd;
   } vec_t;

   initial begin
      vec_t vecs[$];
      int lat;
      logic err, sStr, sLd, mErr;
      logic [31:0] rd, din, mDin, mRd, ra, rdw;
      logic [3:0] sel, mSel;
      logic [9:0] maddr;
      logic [2:0] ro;
      logic rw;

      vecs.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 32'h13,   32'h0,        1'b0, 4'b1000, 32'h0, 32'hFFFFFFDE});
      vecs.push_back('{1'b0, 3'b100, 32'h13,   32'h0,        1'b0, 4'b1000, 32'h0, 32'h000000DE});
      vecs.push_back('{1'b1, 3'b001, 32'h12,   32'h00001234, 1'b0, 4'b1100, 32'h12341234, 32'hDE});
      vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 4'b1111, 32'h0, 32'h1234BEEF});
      vecs.push_back('{1'b0, 3'b001, 32'h11,   32'h0,        1'b1, 4'b0000, 32'h0, 32'h1234BEEF});
      vecs.push_back('{1'b0, 3'b010, 32'h12,   32'h0,        1'b1, 4'b0000, 32'h0, 32'h1234BEEF});
      vecs.push_back('{1'b0, 3'b011, 32'h10,   32'h0,        1'b1, 4'b0000, 32'h0, 32'h1234BEEF});
      vecs.push_back('{1'b1, 3'b010, 32'h1000, 32'h5555AAAA, 1'b1, 4'b0000, 32'h0, 32'h1234BEEF});
      vecs.push_back('{1'b0, 3'b010, 32'h0,    32'h0,        1'b0, 4'b1111, 32'h0, 32'h0});
      vecs.push_back('{1'b1, 3'b000, 32'h5,    32'h000000A5, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0});
      vecs.push_back('{1'b0, 3'b101, 32'h4,    32'h0,        1'b0, 4'b0011, 32'h0, 32'h0000A500});
      vecs.push_back('{1'b0, 3'b001, 32'h4,    32'h0,        1'b0, 4'b0011, 32'h0, 32'hFFFFA500});
      vecs.push_back('{1'b0, 3'b110, 32'h10,   32'h0,        1'b0, 4'b1111, 32'h0, 32'h1234BEEF});

      // Reset state
      #12;
      checkOutput("resetReady", {31'd0, ready}, 32'd1);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      checkOutput("resetErr", {31'd0, addr_err}, 32'd0);
      checkOutput("resetRdata", rdata, 32'd0);
      checkOutput("resetMemOut", {mem_str, mem_ld, mem_sel, 22'd0, mem_addr == 10'd0}, 32'd1);
      checkOutput("resetMemData", mem_data_in, 32'd0);
      @(negedge clk);
      clr_n = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].w, vecs[i].o, vecs[i].a, vecs[i].d, lat, err, rd, sStr, sLd, sel, din, maddr);
         refAccess(vecs[i].w, vecs[i].o, vecs[i].a, vecs[i].d, mErr, mSel, mDin, mRd);
         checkOutput($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].eErr});
         checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].eErr ? 1 : 2);
         checkOutput($sformatf("vec%0d strobes", i), {30'd0, sStr, sLd},
                     {30'd0, vecs[i].w & ~vecs[i].eErr, ~vecs[i].w & ~vecs[i].eErr});
         checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].eRd);
         if (!vecs[i].eErr) begin
            checkOutput($sformatf("vec%0d sel", i), {28'd0, sel}, {28'd0, vecs[i].eSel});
            checkOutput($sformatf("vec%0d maddr", i), {22'd0, maddr}, {22'd0, vecs[i].a[11:2]});
         end
         if (!vecs[i].eErr && vecs[i].w)
            checkOutput($sformatf("vec%0d din", i), din, vecs[i].eDin);
      end
      checkOutput("outOfRangeWord0", memWords[0], 32'h0);

      // Reset during a store's ACCESS cycle
      @(negedge clk);
      req = 1'b1; we = 1'b1; op = 3'b010; addr = 32'h20; wdata = 32'hCAFEBABE;
      @(negedge clk);
      req = 1'b0;
      checkOutput("abortStrBefore", {31'd0, mem_str}, 32'd1);
      clr_n = 1'b0;
      #1;
      checkOutput("abortStrDrop", {31'd0, mem_str}, 32'd0);
      checkOutput("abortReady", {31'd0, ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("abortNoDone", {31'd0, done}, 32'd0);
      end
      clr_n = 1'b1;
      refRdata = 32'd0;
      checkOutput("abortWord8", memWords[8], 32'h0);
      checkOutput("abortRdata", rdata, 32'h0);

      // Range check disabled: out-of-range store wraps to word 0
      @(negedge clk);
      req1 = 1'b1; addr1 = 32'h1000; wdata1 = 32'hCAFEF00D;
      @(negedge clk);
      req1 = 1'b0;
      checkOutput("noRangeMaddr", {22'd0, memAddr1}, 32'd0);
      checkOutput("noRangeStr", {31'd0, memStr1}, 32'd1);
      @(negedge clk);
      checkOutput("noRangeDone", {30'd0, done1, addrErr1}, 32'd2);
      checkOutput("noRangeWord0", memWords1[0], 32'hCAFEF00D);

      // Random accesses against the reference model
      for (int i = 0; i < 200; i++) begin
         rw  = 1'($urandom_range(0, 1));
         ro  = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 7) == 0) ? (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 63))
                                           : 32'($urandom_range(0, 63));
         rdw = $urandom;
         applyStimulus(rw, ro, ra, rdw, lat, err, rd, sStr, sLd, sel, din, maddr);
         refAccess(rw, ro, ra, rdw, mErr, mSel, mDin, mRd);
         checkOutput("rndErr", {31'd0, err}, {31'd0, mErr});
         checkOutput("rndLatency", lat, mErr ? 1 : 2);
         checkOutput("rndStrobes", {30'd0, sStr, sLd}, {30'd0, rw & ~mErr, ~rw & ~mErr});
         checkOutput("rndRdata", rd, mRd);
         if (!mErr) begin
            checkOutput("rndSel", {28'd0, sel}, {28'd0, mSel});
            checkOutput("rndMaddr", {22'd0, maddr}, {22'd0, ra[11:2]});
            if (rw) checkOutput("rndDin", din, mDin);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
